// File: rtl/lpc_io_ctrl.sv
// rtl/lpc_io_ctrl.sv - LPC I/O-cycle target sequencer for the UART register bank
// Claims I/O reads/writes in an 8-byte window and holds the bus with long-wait SYNC until the bank acks.
module lpc_io_ctrl #(
  parameter logic [15:0] BASE_ADDR  = 16'h03F8,
  parameter int          TAR_CYCLES = 1,
  parameter int          WAIT_MAX   = 255
) (
  input  logic       lpc_clk,
  input  logic       lpc_rst,
  input  logic       lpc_frame,
  input  logic [3:0] lpc_ad_in,
  output logic [3:0] lpc_ad_out,
  output logic       lpc_ad_oe,
  output logic [2:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  input  logic       reg_ack,
  output logic       cycle_active,
  output logic       sync_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_CTDIR, S_ADDR0, S_ADDR1, S_ADDR2, S_ADDR3,
    S_WDATA0, S_WDATA1, S_TAR, S_SYNC, S_RDATA0, S_RDATA1,
    S_TAR_END, S_IGNORE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [11:0] r_addr;
  logic        r_is_write;
  logic        r_ack_seen;
  logic [1:0]  r_tar_cnt;
  logic [7:0]  r_wait_cnt;
  logic [7:0]  r_rdata;
  logic [7:0]  r_wdata;
  logic [2:0]  r_reg_addr;

  logic        w_match;
  logic        w_ack_now;
  logic        w_timeout;
  logic        w_tar_last;
  logic        w_strobe_slot;

  assign w_match       = ({r_addr, lpc_ad_in[3]} == BASE_ADDR[15:3]);
  assign w_ack_now     = r_ack_seen | reg_ack;
  assign w_timeout     = !w_ack_now && (r_wait_cnt == 8'(WAIT_MAX));
  assign w_tar_last    = (r_tar_cnt == 2'(TAR_CYCLES - 1));
  // Strobe is suppressed when the host reasserts LFRAME# so an abort never touches the bank.
  assign w_strobe_slot = (r_state == S_TAR) && (r_tar_cnt == 2'd0) && lpc_frame;

  assign reg_wr       = w_strobe_slot && r_is_write;
  assign reg_rd       = w_strobe_slot && !r_is_write;
  assign reg_addr     = r_reg_addr;
  assign reg_wdata    = r_wdata;
  assign cycle_active = (r_state == S_WDATA0) || (r_state == S_WDATA1) ||
                        (r_state == S_TAR)    || (r_state == S_SYNC)   ||
                        (r_state == S_RDATA0) || (r_state == S_RDATA1) ||
                        (r_state == S_TAR_END);

  always_comb begin
    w_next = r_state;
    if (!lpc_frame) begin
      w_next = (lpc_ad_in == 4'h0) ? S_CTDIR : S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    w_next = S_IDLE;
        S_CTDIR:   w_next = (lpc_ad_in == 4'h0 || lpc_ad_in == 4'h2) ? S_ADDR0 : S_IGNORE;
        S_ADDR0:   w_next = S_ADDR1;
        S_ADDR1:   w_next = S_ADDR2;
        S_ADDR2:   w_next = S_ADDR3;
        S_ADDR3: begin
          if (!w_match)       w_next = S_IGNORE;
          else if (r_is_write) w_next = S_WDATA0;
          else                w_next = S_TAR;
        end
        S_WDATA0:  w_next = S_WDATA1;
        S_WDATA1:  w_next = S_TAR;
        S_TAR:     w_next = w_tar_last ? S_SYNC : S_TAR;
        S_SYNC: begin
          if (w_ack_now)      w_next = r_is_write ? S_TAR_END : S_RDATA0;
          else if (w_timeout) w_next = S_TAR_END;
        end
        S_RDATA0:  w_next = S_RDATA1;
        S_RDATA1:  w_next = S_TAR_END;
        S_TAR_END: w_next = S_IDLE;
        S_IGNORE:  w_next = S_IGNORE;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    lpc_ad_oe  = 1'b0;
    lpc_ad_out = 4'hF;
    sync_err   = 1'b0;
    case (r_state)
      S_SYNC: begin
        lpc_ad_oe = 1'b1;
        if (w_ack_now) begin
          lpc_ad_out = 4'h0;
        end else if (w_timeout) begin
          lpc_ad_out = 4'hA;
          sync_err   = 1'b1;
        end else begin
          lpc_ad_out = 4'h6;
        end
      end
      S_RDATA0: begin
        lpc_ad_oe  = 1'b1;
        lpc_ad_out = r_rdata[3:0];
      end
      S_RDATA1: begin
        lpc_ad_oe  = 1'b1;
        lpc_ad_out = r_rdata[7:4];
      end
      S_TAR_END: begin
        lpc_ad_oe  = 1'b1;
        lpc_ad_out = 4'hF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge lpc_clk) begin
    if (lpc_rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_is_write <= 1'b0;
      r_ack_seen <= 1'b0;
      r_tar_cnt  <= '0;
      r_wait_cnt <= '0;
      r_rdata    <= '0;
      r_wdata    <= '0;
      r_reg_addr <= '0;
    end else begin
      r_state <= w_next;
      if (lpc_frame) begin
        case (r_state)
          S_CTDIR: begin
            r_is_write <= (lpc_ad_in == 4'h2);
            r_ack_seen <= 1'b0;
            r_tar_cnt  <= '0;
            r_wait_cnt <= '0;
          end
          S_ADDR0, S_ADDR1, S_ADDR2: r_addr <= {r_addr[7:0], lpc_ad_in};
          S_ADDR3: if (w_match) r_reg_addr <= lpc_ad_in[2:0];
          S_WDATA0: r_wdata[3:0] <= lpc_ad_in;
          S_WDATA1: r_wdata[7:4] <= lpc_ad_in;
          S_TAR, S_SYNC: begin
            if (r_state == S_TAR) r_tar_cnt <= r_tar_cnt + 2'd1;
            // First ack wins; later acks from a misbehaving bank must not corrupt read data.
            if (reg_ack && !r_ack_seen) begin
              r_ack_seen <= 1'b1;
              if (!r_is_write) r_rdata <= reg_rdata;
            end
            if (r_state == S_SYNC && !w_ack_now && !w_timeout) r_wait_cnt <= r_wait_cnt + 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lpc_io_ctrl.sv
// tb/tb_lpc_io_ctrl.sv - scoreboard bench for lpc_io_ctrl with randomized I/O cycles
module tb_lpc_io_ctrl;
  localparam logic [15:0] BASE  = 16'h03F8;
  localparam int          TAR   = 1;
  localparam int          WMAX  = 255;

  logic       lpc_clk = 1'b0;
  logic       lpc_rst;
  logic       lpc_frame;
  logic [3:0] lpc_ad_in;
  logic [3:0] lpc_ad_out;
  logic       lpc_ad_oe;
  logic [2:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_rdata;
  logic       reg_ack;
  logic       cycle_active;
  logic       sync_err;

  lpc_io_ctrl #(.BASE_ADDR(BASE), .TAR_CYCLES(TAR), .WAIT_MAX(WMAX)) dut (
    .lpc_clk(lpc_clk), .lpc_rst(lpc_rst), .lpc_frame(lpc_frame), .lpc_ad_in(lpc_ad_in),
    .lpc_ad_out(lpc_ad_out), .lpc_ad_oe(lpc_ad_oe), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_rdata(reg_rdata), .reg_ack(reg_ack),
    .cycle_active(cycle_active), .sync_err(sync_err)
  );

  always #5 lpc_clk = ~lpc_clk;

  typedef struct {
    logic       wr;
    logic [2:0] a;
    logic [7:0] d;
  } strb_t;

  strb_t      exp_strb[$];
  logic [4:0] exp_nib[$];   // {sync_err, lad}
  int n_checks = 0;
  int n_err    = 0;
  int nib_seen = 0;
  int bank_delay = -1;
  logic [7:0] bank_rdata = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Register bank: acks `bank_delay` cycles after the strobe (0 = same cycle, <0 = never).
  initial begin
    int cd;
    cd = 0;
    reg_ack   = 1'b0;
    reg_rdata = 8'h00;
    forever begin
      @(posedge lpc_clk); #2;
      reg_ack   = 1'b0;
      reg_rdata = 8'($urandom);
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin reg_ack = 1'b1; reg_rdata = bank_rdata; end
      end
      if (reg_wr || reg_rd) begin
        if (bank_delay == 0) begin reg_ack = 1'b1; reg_rdata = bank_rdata; end
        else if (bank_delay > 0) cd = bank_delay;
      end
    end
  end

  // Monitor: every strobe and every driven LAD nibble is matched against the scoreboard.
  initial begin
    strb_t s;
    logic [4:0] n;
    forever begin
      @(negedge lpc_clk);
      if (reg_wr && reg_rd) check("strobe_both", 32'(reg_wr & reg_rd), 32'd0);
      if (reg_wr || reg_rd) begin
        if (exp_strb.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL strobe_unexpected: got wr=%0b rd=%0b addr=%0d expected none", reg_wr, reg_rd, reg_addr);
        end else begin
          s = exp_strb.pop_front();
          check("strobe_kind", 32'(reg_wr), 32'(s.wr));
          check("strobe_addr", 32'(reg_addr), 32'(s.a));
          if (s.wr) check("strobe_wdata", 32'(reg_wdata), 32'(s.d));
        end
      end
      if (lpc_ad_oe) begin
        nib_seen++;
        if (exp_nib.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL lad_unexpected: got oe=1 lad=%0h err=%0b expected oe=0", lpc_ad_out, sync_err);
        end else begin
          n = exp_nib.pop_front();
          check("lad_nibble", 32'({sync_err, lpc_ad_out}), 32'(n));
        end
      end else if (sync_err) begin
        check("sync_err_no_oe", 32'(sync_err), 32'd0);
      end
    end
  end

  task automatic drive(input logic fr, input logic [3:0] ad);
    @(posedge lpc_clk); #1;
    lpc_frame = fr;
    lpc_ad_in = ad;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_oe"},     32'(lpc_ad_oe),    32'd0);
    check({tag, "_lad"},    32'(lpc_ad_out),   32'hF);
    check({tag, "_wr"},     32'(reg_wr),       32'd0);
    check({tag, "_rd"},     32'(reg_rd),       32'd0);
    check({tag, "_addr"},   32'(reg_addr),     32'd0);
    check({tag, "_wdata"},  32'(reg_wdata),    32'd0);
    check({tag, "_active"}, 32'(cycle_active), 32'd0);
    check({tag, "_err"},    32'(sync_err),     32'd0);
  endtask

  // Reference: the host sees TAR turnaround, then SYNC until the ack is visible (sticky from the
  // strobe cycle), a timeout 4'hA once WAIT_MAX long-waits have elapsed, data nibbles, then 4'hF.
  task automatic lpc_cycle(input bit wr, input logic [15:0] addr, input logic [7:0] wd,
                           input logic [7:0] rd, input int dly);
    bit claimed;
    bit acked;
    bit seen;
    bit done;
    int eff;
    claimed = (addr[15:3] == BASE[15:3]);
    bank_delay = dly;
    bank_rdata = rd;
    if (claimed) begin
      exp_strb.push_back('{wr, addr[2:0], wd});
      eff = (dly < 0) ? 1000000 : dly;
      acked = 1'b0;
      for (int j = 1; j <= WMAX + 1; j++) begin
        if (eff <= TAR - 1 + j) begin exp_nib.push_back(5'h00); acked = 1'b1; break; end
        if (j - 1 == WMAX) begin exp_nib.push_back(5'h1A); break; end
        exp_nib.push_back(5'h06);
      end
      if (acked && !wr) begin
        exp_nib.push_back({1'b0, rd[3:0]});
        exp_nib.push_back({1'b0, rd[7:4]});
      end
      exp_nib.push_back(5'h0F);
    end
    drive(1'b0, 4'h0);
    drive(1'b1, wr ? 4'h2 : 4'h0);
    for (int i = 3; i >= 0; i--) drive(1'b1, addr[i*4 +: 4]);
    if (wr) begin
      drive(1'b1, wd[3:0]);
      drive(1'b1, wd[7:4]);
    end
    drive(1'b1, 4'hF);
    @(negedge lpc_clk);
    check("active_in_tar", 32'(cycle_active), 32'(claimed));
    if (claimed) begin
      seen = 1'b0;
      done = 1'b0;
      for (int i = 0; i < 400; i++) begin
        @(negedge lpc_clk);
        if (lpc_ad_oe) seen = 1'b1;
        else if (seen) begin done = 1'b1; break; end
      end
      check("cycle_done", 32'(done), 32'd1);
      check("active_after", 32'(cycle_active), 32'd0);
    end else begin
      repeat (3) @(negedge lpc_clk);
      check("active_ignored", 32'(cycle_active), 32'd0);
    end
  endtask

  initial begin
    int base;
    bit hit;
    bit wr;
    logic [15:0] addr;
    lpc_rst   = 1'b1;
    lpc_frame = 1'b1;
    lpc_ad_in = 4'hF;
    repeat (3) @(posedge lpc_clk);
    @(negedge lpc_clk);
    check_reset_vals("reset");
    @(posedge lpc_clk); #1;
    lpc_rst = 1'b0;

    lpc_cycle(1'b1, 16'h03F8, 8'h5A, 8'h00, 0);     // write, ack in strobe cycle
    lpc_cycle(1'b0, 16'h03FD, 8'h00, 8'h60, 3);     // read, SYNC 6,6,0 then 0,6,F
    lpc_cycle(1'b1, 16'h02F8, 8'h33, 8'h00, 0);     // outside window
    drive(1'b0, 4'h0); drive(1'b1, 4'h0); drive(1'b1, 4'h0); drive(1'b1, 4'h3);
    lpc_cycle(1'b0, 16'h03F8, 8'h00, 8'hC3, 1);     // START during ADDR2 restarts
    lpc_cycle(1'b0, 16'h03F9, 8'h00, 8'h00, -1);    // long-wait timeout
    lpc_cycle(1'b0, 16'h03FF, 8'h00, 8'h9E, 0);

    // Reset mid-SYNC after ten long-wait nibbles; the eleventh is driven before reset is sampled.
    bank_delay = -1;
    exp_strb.push_back('{1'b0, 3'd4, 8'h00});
    repeat (11) exp_nib.push_back(5'h06);
    drive(1'b0, 4'h0); drive(1'b1, 4'h0);
    drive(1'b1, 4'h0); drive(1'b1, 4'h3); drive(1'b1, 4'hF); drive(1'b1, 4'hC);
    drive(1'b1, 4'hF);
    base = nib_seen;
    hit  = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge lpc_clk);
      if (nib_seen - base >= 10) begin hit = 1'b1; break; end
    end
    check("sync_reached", 32'(hit), 32'd1);
    #1 lpc_rst = 1'b1;
    @(posedge lpc_clk);
    @(negedge lpc_clk);
    check_reset_vals("midsync_reset");
    @(posedge lpc_clk); #1;
    lpc_rst = 1'b0;
    lpc_cycle(1'b1, 16'h03FB, 8'hE7, 8'h00, 2);

    for (int t = 0; t < 40; t++) begin
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) addr = 16'($urandom);
      else addr = BASE + 16'($urandom_range(0, 7));
      lpc_cycle(wr, addr, 8'($urandom), 8'($urandom), int'($urandom_range(0, 6)));
    end

    repeat (5) @(negedge lpc_clk);
    check("strobes_left", 32'(exp_strb.size()), 32'd0);
    check("nibbles_left", 32'(exp_nib.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
